// File: rtl/charmatrix_sequencer.sv
// charmatrix_sequencer: character byte stream -> per-LED GRB pixel stream.
// Bytes are stored with a colour index in an N-entry text buffer. Each refresh
// tick snapshots the buffer, then streams one 24-bit word per glyph bit.
// Build option: define CHARMATRIX_SCROLL_EN to make stored bytes scroll in from
// the right instead of overwriting through a circular write pointer.
//
// state          | meaning
// S_IDLE         | counters cleared, waiting for a refresh tick
// S_LOAD         | present ROM addresses for the current character
// S_WAIT_READY   | wait for the driver to be idle, then raise px_valid
// S_WAIT_STARTED | wait for the driver to take the pixel, then advance
module charmatrix_sequencer #(
  parameter int NUM_CHARS      = 4,
  parameter int CHAR_W         = 5,
  parameter int CHAR_H         = 7,
  parameter int COLOR_BITS     = 4,
  parameter int REFRESH_CYCLES = 262144
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_valid,
  output logic                       o_rx_ready,
  input  logic [COLOR_BITS-1:0]      i_rnd_color,
  output logic [7:0]                 o_char_index,
  input  logic [CHAR_W*CHAR_H-1:0]   i_char_data,
  output logic [COLOR_BITS-1:0]      o_color_index,
  input  logic [23:0]                i_color_data,
  output logic [23:0]                o_px_data,
  output logic                       o_px_valid,
  output logic                       o_px_latch,
  input  logic                       i_px_ready,
  output logic                       o_frame_busy
);

  localparam int GLYPH_BITS = CHAR_W * CHAR_H;
  localparam int NUM_LEDS   = NUM_CHARS * GLYPH_BITS;
  localparam int CW = $clog2(NUM_CHARS);
  localparam int GW = $clog2(GLYPH_BITS);
  localparam int LW = $clog2(NUM_LEDS);
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam logic [CW-1:0] CHAR_LAST    = CW'(NUM_CHARS - 1);
  localparam logic [GW-1:0] GBIT_LAST    = GW'(GLYPH_BITS - 1);
  localparam logic [LW-1:0] LED_LAST     = LW'(NUM_LEDS - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [7:0]    FORM_FEED    = 8'h0C;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_READY, S_WAIT_STARTED} state_t;

  state_t r_state, w_next;

  logic [7:0]            r_textbuf    [NUM_CHARS];
  logic [COLOR_BITS-1:0] r_colorbuf   [NUM_CHARS];
  logic [7:0]            r_shadow_text[NUM_CHARS];
  logic [COLOR_BITS-1:0] r_shadow_col [NUM_CHARS];
`ifndef CHARMATRIX_SCROLL_EN
  logic [CW-1:0]         r_wp;
`endif
  logic                  r_rx_ready;
  logic [RW-1:0]         r_refresh;
  logic [LW-1:0]         r_led;
  logic [GW-1:0]         r_gbit;
  logic [CW-1:0]         r_ci;
  logic                  r_px_valid;
  logic [7:0]            r_char_index;
  logic [COLOR_BITS-1:0] r_color_index;

  logic w_accept, w_tick, w_snap, w_load, w_set_valid, w_advance, w_clear_cnt;

  assign w_accept = i_rx_valid & r_rx_ready;
  assign w_tick   = (r_refresh == REFRESH_LAST);

  // Ready drops for one cycle after every accepted byte.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_rx_ready <= 1'b0;
    else         r_rx_ready <= ~w_accept;
  end

  // Live text/colour buffers: form feed clears, other bytes are stored.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        r_textbuf[i]  <= '0;
        r_colorbuf[i] <= '0;
      end
`ifndef CHARMATRIX_SCROLL_EN
      r_wp <= '0;
`endif
    end else if (w_accept) begin
      if (i_rx_data == FORM_FEED) begin
        for (int i = 0; i < NUM_CHARS; i++) begin
          r_textbuf[i]  <= '0;
          r_colorbuf[i] <= '0;
        end
`ifndef CHARMATRIX_SCROLL_EN
        r_wp <= '0;
`endif
      end else begin
`ifdef CHARMATRIX_SCROLL_EN
        for (int i = 0; i < NUM_CHARS - 1; i++) begin
          r_textbuf[i]  <= r_textbuf[i+1];
          r_colorbuf[i] <= r_colorbuf[i+1];
        end
        r_textbuf[NUM_CHARS-1]  <= i_rx_data;
        r_colorbuf[NUM_CHARS-1] <= i_rnd_color;
`else
        r_textbuf[r_wp]  <= i_rx_data;
        r_colorbuf[r_wp] <= i_rnd_color;
        r_wp <= (r_wp == CHAR_LAST) ? '0 : r_wp + CW'(1);
`endif
      end
    end
  end

  // Free-running refresh counter; ticks are not stalled by a busy frame.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_refresh <= '0;
    else         r_refresh <= w_tick ? '0 : r_refresh + RW'(1);
  end

  // Snapshot so RX writes during a frame never disturb it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        r_shadow_text[i] <= '0;
        r_shadow_col[i]  <= '0;
      end
    end else if (w_snap) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        r_shadow_text[i] <= r_textbuf[i];
        r_shadow_col[i]  <= r_colorbuf[i];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state and datapath strobes.
  always_comb begin
    w_next      = r_state;
    w_snap      = 1'b0;
    w_load      = 1'b0;
    w_set_valid = 1'b0;
    w_advance   = 1'b0;
    w_clear_cnt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clear_cnt = 1'b1;
        if (w_tick) begin
          w_snap = 1'b1;
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_next = S_WAIT_READY;
      end
      S_WAIT_READY: begin
        if (i_px_ready) begin
          w_set_valid = 1'b1;
          w_next      = S_WAIT_STARTED;
        end
      end
      S_WAIT_STARTED: begin
        if (!i_px_ready) begin
          w_advance = 1'b1;
          w_next    = (r_led == LED_LAST) ? S_IDLE : S_LOAD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // LED, glyph-bit and character counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_led  <= '0;
      r_gbit <= '0;
      r_ci   <= '0;
    end else if (w_clear_cnt) begin
      r_led  <= '0;
      r_gbit <= '0;
      r_ci   <= '0;
    end else if (w_advance) begin
      r_led <= r_led + LW'(1);
      if (r_gbit == GBIT_LAST) begin
        r_gbit <= '0;
        r_ci   <= (r_ci == CHAR_LAST) ? '0 : r_ci + CW'(1);
      end else begin
        r_gbit <= r_gbit + GW'(1);
      end
    end
  end

  // ROM addresses and pixel request handshake.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_char_index  <= '0;
      r_color_index <= '0;
      r_px_valid    <= 1'b0;
    end else begin
      if (w_load) begin
        r_char_index  <= r_shadow_text[r_ci];
        r_color_index <= r_shadow_col[r_ci];
      end
      if (w_set_valid)    r_px_valid <= 1'b1;
      else if (w_advance) r_px_valid <= 1'b0;
    end
  end

  assign o_rx_ready    = r_rx_ready;
  assign o_char_index  = r_char_index;
  assign o_color_index = r_color_index;
  assign o_px_valid    = r_px_valid;
  assign o_px_data     = i_char_data[r_gbit] ? i_color_data : 24'h0;
  assign o_px_latch    = (r_led == LED_LAST);
  assign o_frame_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_charmatrix_sequencer.sv
// Bench for charmatrix_sequencer: random byte stream and a randomly stalling
// strip driver; a scoreboard queue holds the pixels each frame should carry.
module tb_charmatrix_sequencer;

  localparam int NC = 4;
  localparam int CWD = 5;
  localparam int CHT = 7;
  localparam int GB = CWD * CHT;
  localparam int NL = NC * GB;
  localparam int R = 64;

  logic clk, reset;
  logic [7:0] rx_data;
  logic rx_valid, rx_ready;
  logic [3:0] rnd_color;
  logic [7:0] char_index;
  logic [GB-1:0] char_data;
  logic [3:0] color_index;
  logic [23:0] color_data, px_data;
  logic px_valid, px_latch, px_ready, frame_busy;

  charmatrix_sequencer #(.NUM_CHARS(NC), .CHAR_W(CWD), .CHAR_H(CHT),
                         .COLOR_BITS(4), .REFRESH_CYCLES(R)) dut (
    .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready), .i_rnd_color(rnd_color), .o_char_index(char_index),
    .i_char_data(char_data), .o_color_index(color_index), .i_color_data(color_data),
    .o_px_data(px_data), .o_px_valid(px_valid), .o_px_latch(px_latch),
    .i_px_ready(px_ready), .o_frame_busy(frame_busy));

  // External ROMs; glyph of character 0 is blank.
  function automatic logic [GB-1:0] glyph_f(input logic [7:0] c);
    logic [7:0] m;
    m = c * 8'd7;
    return {c[2:0], c ^ {c[3:0], c[7:4]}, m, c, c + c};
  endfunction
  function automatic logic [23:0] color_f(input logic [3:0] i);
    return {i, 4'hA, ~i, i, 4'h3, i ^ 4'h5};
  endfunction
  assign char_data  = glyph_f(char_index);
  assign color_data = color_f(color_index);

  typedef struct { logic [23:0] d; logic l; logic [7:0] ci; logic [3:0] co; } exp_t;
  exp_t exp_q[$];
  logic [11:0] tx_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, rel_cyc = 0, idle_from = 0, t_tick = -100;
  int pix_cnt = 0, hold = 0, frames_done = 0, m_wp = 0;
  bit m_ready = 0, m_busy = 0, acc_prev = 0, rdy_t2 = 0, fixed30 = 0, rand_tx = 0;
  logic [7:0] m_text[NC];
  logic [3:0] m_col[NC];

  initial begin clk = 0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) begin m_text[i] = 0; m_col[i] = 0; end
    m_wp = 0;
  endtask

  task automatic model_write(input logic [7:0] b, input logic [3:0] c);
    if (b == 8'h0C) model_clear();
    else begin
`ifdef CHARMATRIX_SCROLL_EN
      for (int i = 0; i < NC - 1; i++) begin m_text[i] = m_text[i+1]; m_col[i] = m_col[i+1]; end
      m_text[NC-1] = b; m_col[NC-1] = c;
`else
      m_text[m_wp] = b; m_col[m_wp] = c;
      m_wp = (m_wp + 1) % NC;
`endif
    end
  endtask

  task automatic push_frame();
    exp_t e;
    logic [GB-1:0] g;
    int ch, b;
    for (int led = 0; led < NL; led++) begin
      ch = led / GB; b = led % GB;
      g = glyph_f(m_text[ch]);
      e.d  = g[b] ? color_f(m_col[ch]) : 24'h0;
      e.l  = (led == NL - 1);
      e.ci = m_text[ch];
      e.co = m_col[ch];
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [11:0] rand_byte();
    logic [7:0] b;
    b = ($urandom_range(0, 15) == 0) ? 8'h0C : 8'($urandom_range(8'h20, 8'h7E));
    return {4'($urandom_range(0, 15)), b};
  endfunction

  // One clock of stimulus, reference model and driver model.
  task automatic step();
    int k;
    bit accept;
    logic [11:0] w;
    @(negedge clk);
    k = cyc - rel_cyc;
    chk("rx_ready", rx_ready, m_ready);
    if (cyc == t_tick + 1) chk("busy_after_tick", frame_busy, 1);
    if (cyc == t_tick + 2) chk("valid_tick_plus2", px_valid, 0);
    if (cyc == t_tick + 3 && rdy_t2) chk("valid_tick_plus3", px_valid, 1);
    if ((k % R) == R - 1 && !m_busy && cyc >= idle_from) begin
      chk("busy_at_tick", frame_busy, 0);
      push_frame();
      m_busy = 1;
      t_tick = cyc;
    end
    if (rand_tx && tx_q.size() < 2 && $urandom_range(0, 7) == 0) tx_q.push_back(rand_byte());
    if (acc_prev) rx_valid = 0;
    if (!rx_valid && tx_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      w = tx_q.pop_front();
      rx_data = w[7:0]; rnd_color = w[11:8]; rx_valid = 1;
    end
    accept = rx_valid && m_ready;
    acc_prev = accept;
    if (accept) model_write(rx_data, rnd_color);
    m_ready = !accept;
    if (hold > 0) begin
      hold--;
      if (hold == 0) px_ready = 1;
    end else if (px_valid && px_ready) begin
      px_ready = 0;
      hold = fixed30 ? 30 : $urandom_range(1, 6);
      pix_cnt++;
      if (pix_cnt == NL) begin
        pix_cnt = 0; m_busy = 0; idle_from = cyc + 1; frames_done++;
      end
    end
    if (cyc == t_tick + 2) rdy_t2 = px_ready;
  endtask

  task automatic wait_frames(input int n);
    int target, budget;
    target = frames_done + n;
    budget = 20000;
    while (frames_done < target && budget > 0) begin step(); budget--; end
    chk("frame_timeout", frames_done >= target, 1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 0;
    rel_cyc = cyc;
    chk("rx_ready_release", rx_ready, 0);
    m_ready = 1;
  endtask

  task automatic tb_reset_state();
    model_clear();
    exp_q.delete(); tx_q.delete();
    m_busy = 0; pix_cnt = 0; hold = 0; idle_from = 0; t_tick = -100;
    acc_prev = 0; rx_valid = 0; px_ready = 1;
  endtask

  // Monitor: each rising px_valid presents one pixel to the scoreboard.
  initial begin
    exp_t e;
    logic pv;
    pv = 0;
    forever begin
      @(negedge clk);
      if (px_valid && !pv && !reset) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL px_extra: got pixel %0h expected none", px_data);
        end else begin
          e = exp_q.pop_front();
          chk("px_data", px_data, e.d);
          chk("px_latch", px_latch, e.l);
          chk("char_index", char_index, e.ci);
          chk("color_index", color_index, e.co);
        end
      end
      pv = px_valid;
    end
  end

  initial begin
    int budget;
    reset = 1; rx_valid = 0; rx_data = 0; rnd_color = 0; px_ready = 1;
    model_clear();
    #12;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_px_valid", px_valid, 0);
    chk("rst_frame_busy", frame_busy, 0);
    chk("rst_char_index", char_index, 0);
    chk("rst_color_index", color_index, 0);
    @(negedge clk);
    release_reset();

    // Two characters, slow driver (30 idle cycles per pixel).
    fixed30 = 1;
    tx_q.push_back({4'd3, 8'h41});
    tx_q.push_back({4'd5, 8'h42});
    wait_frames(1);
    fixed30 = 0;

    // Random traffic, writes landing during frames.
    rand_tx = 1;
    wait_frames(3);
    rand_tx = 0;

    // Five bytes into four entries, then clear with form feed.
    for (int i = 0; i < 5; i++) tx_q.push_back({4'(i + 1), 8'(8'h61 + i)});
    wait_frames(2);
    for (int i = 0; i < 3; i++) tx_q.push_back({4'(i + 7), 8'(8'h30 + i)});
    tx_q.push_back({4'd9, 8'h0C});
    wait_frames(2);
    tx_q.push_back({4'd12, 8'h5A});
    wait_frames(1);

    // Reset while a pixel is being taken by the driver.
    rand_tx = 1;
    budget = 20000;
    while (!(px_valid && pix_cnt > 5) && budget > 0) begin step(); budget--; end
    chk("midreset_reached", px_valid, 1);
    #1 reset = 1;
    #1;
    chk("midrst_px_valid", px_valid, 0);
    chk("midrst_frame_busy", frame_busy, 0);
    chk("midrst_rx_ready", rx_ready, 0);
    tb_reset_state();
    @(negedge clk);
    release_reset();
    wait_frames(2);
    rand_tx = 0;
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
